usb_tx_scheduler: RTL and testbench

Sequences the USB transmit FSM and shares it between two requesters: the receive-side handshake path (ACK/NACK) and the host-side data path. It issues one-cycle tx_packet commands, tracks each packet to tx_done, enforces a minimum inter-packet gap, and aborts through a watchdog when tx_done never arrives. It sits between the RX protocol logic / AHB slave and the transmit FSM.

---
 rtl/usb_tx_scheduler.sv | 116 +++++++++++
 tb/tb_usb_tx_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: shares the transmit FSM between ACK/NACK handshakes and host data,
// tracking each packet to tx_done with an inter-packet gap and a tx_done watchdog.
module usb_tx_scheduler #(
   parameter int unsigned GAP_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2048
) (
   input  logic       clk_i,
   input  logic       n_rst_i,
   input  logic       ack_req_i,
   input  logic       nack_req_i,
   input  logic       data_req_i,
   input  logic [6:0] data_size_i,
   input  logic [6:0] buffer_occupancy_i,
   input  logic       tx_done_i,
   output logic [1:0] tx_packet_o,
   output logic [6:0] tx_packet_data_size_o,
   output logic       busy_o,
   output logic       ack_sent_o,
   output logic       nack_sent_o,
   output logic       data_sent_o,
   output logic       data_abort_o,
   output logic       tx_timeout_o
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ABORT = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;
   localparam logic [1:0] K_DATA  = 2'b01;
   localparam logic [1:0] K_ACK   = 2'b10;
   localparam logic [1:0] K_NACK  = 2'b11;
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic [1:0]  kind_q, kind_d;
   logic [15:0] cnt_q, cnt_d, cnt_inc;
   logic [6:0]  size_q, size_d;
   logic        ack_pend_q, ack_pend_d, nack_pend_q, nack_pend_d;
   logic        ack_any, nack_any, data_ok;

   // The IDLE decision sees this cycle's request pulses so a handshake always beats data.
   always_comb begin
      ack_any     = ack_pend_q | ack_req_i;
      nack_any    = nack_pend_q | nack_req_i;
      data_ok     = data_req_i && (buffer_occupancy_i >= data_size_i);
      cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      state_d     = state_q;
      kind_d      = kind_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      ack_pend_d  = (state_q == S_ISSUE && kind_q != K_DATA) ? ack_req_i : ack_any;
      nack_pend_d = (state_q == S_ISSUE && kind_q != K_DATA) ? nack_req_i : nack_any;
      case (state_q)
         S_IDLE: begin
            if (nack_any) begin
               kind_d  = K_NACK;
               state_d = S_ISSUE;
            end else if (ack_any) begin
               kind_d  = K_ACK;
               state_d = S_ISSUE;
            end else if (data_ok) begin
               kind_d  = K_DATA;
               size_d  = data_size_i;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            cnt_d   = 16'd0;
         end
         S_WAIT: begin
            if (tx_done_i) state_d = S_DONE;
            else if (cnt_q >= TO_LAST) state_d = S_ABORT;
            else cnt_d = cnt_inc;
         end
         S_DONE, S_ABORT: begin
            state_d = S_GAP;
            cnt_d   = 16'd0;
         end
         S_GAP: begin
            if (cnt_q >= GAP_LAST) state_d = S_IDLE;
            else cnt_d = cnt_inc;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!n_rst_i) begin
         state_q     <= S_IDLE;
         kind_q      <= 2'b00;
         cnt_q       <= 16'd0;
         size_q      <= 7'd0;
         ack_pend_q  <= 1'b0;
         nack_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         ack_pend_q  <= ack_pend_d;
         nack_pend_q <= nack_pend_d;
      end
   end

   assign tx_packet_o           = (state_q == S_ISSUE) ? kind_q : 2'b00;
   assign tx_packet_data_size_o = size_q;
   assign busy_o                = state_q != S_IDLE;
   assign ack_sent_o            = state_q == S_DONE && kind_q == K_ACK;
   assign nack_sent_o           = state_q == S_DONE && kind_q == K_NACK;
   assign data_sent_o           = state_q == S_DONE && kind_q == K_DATA;
   assign data_abort_o          = state_q == S_ABORT && kind_q == K_DATA;
   assign tx_timeout_o          = state_q == S_ABORT;
endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb_usb_tx_scheduler: directed and random stimulus checked every cycle against a
// timestamp-based transaction model of the scheduler.
module tb_usb_tx_scheduler;
   localparam int GAP = 4;
   localparam int TO  = 24;

   logic       clk = 0, n_rst = 0, ack_req = 0, nack_req = 0, data_req = 0, tx_done = 0;
   logic [6:0] data_size = 0, occ = 0;
   logic [1:0] tx_packet;
   logic [6:0] tx_size;
   logic       busy, ack_sent, nack_sent, data_sent, data_abort, tx_timeout;
   logic [14:0] outv;
   int n_vec = 0, n_err = 0, cyc = 0;
   bit armed = 0;

   // transaction model: one packet in flight described by the cycles of its milestones
   bit         m_act = 0, m_abrt = 0, m_pa = 0, m_pn = 0;
   logic [1:0] m_kind = 0;
   logic [6:0] m_sz = 0;
   int         m_issue_t = 0, m_end_t = -1, m_idle_t = 0;

   always #5 clk = ~clk;

   usb_tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .n_rst_i(n_rst), .ack_req_i(ack_req), .nack_req_i(nack_req),
      .data_req_i(data_req), .data_size_i(data_size), .buffer_occupancy_i(occ),
      .tx_done_i(tx_done), .tx_packet_o(tx_packet), .tx_packet_data_size_o(tx_size),
      .busy_o(busy), .ack_sent_o(ack_sent), .nack_sent_o(nack_sent),
      .data_sent_o(data_sent), .data_abort_o(data_abort), .tx_timeout_o(tx_timeout)
   );

   assign outv = {tx_packet, tx_size, busy, ack_sent, nack_sent, data_sent, data_abort, tx_timeout};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(posedge clk) begin
      int p;
      bit npa, npn;
      logic [1:0] k;
      logic [14:0] e;
      bit fin;
      p = cyc;
      cyc++;
      if (!n_rst) begin
         m_act = 0; m_pa = 0; m_pn = 0; m_sz = 0; armed = 1;
      end else begin
         if (m_act && p >= m_idle_t) m_act = 0;
         npa = m_pa | ack_req;
         npn = m_pn | nack_req;
         if (m_act) begin
            if (p == m_issue_t && m_kind != 2'b01) begin
               npa = ack_req;
               npn = nack_req;
            end
            if (m_end_t < 0 && p > m_issue_t) begin
               if (tx_done) begin
                  m_end_t = p + 1; m_abrt = 0; m_idle_t = p + 2 + GAP;
               end else if (p == m_issue_t + TO) begin
                  m_end_t = p + 1; m_abrt = 1; m_idle_t = p + 2 + GAP;
               end
            end
         end else begin
            k = npn ? 2'b11 : npa ? 2'b10 : (data_req && occ >= data_size) ? 2'b01 : 2'b00;
            if (k != 2'b00) begin
               m_act = 1; m_kind = k; m_issue_t = p + 1; m_end_t = -1; m_idle_t = 1 << 30;
               if (k == 2'b01) m_sz = data_size;
            end
         end
         m_pa = npa;
         m_pn = npn;
      end
      #1;
      if (armed) begin
         fin = m_act && cyc == m_end_t;
         e = {(m_act && cyc == m_issue_t) ? m_kind : 2'b00, m_sz, m_act && cyc < m_idle_t,
              fin && !m_abrt && m_kind == 2'b10, fin && !m_abrt && m_kind == 2'b11,
              fin && !m_abrt && m_kind == 2'b01, fin && m_abrt && m_kind == 2'b01, fin && m_abrt};
         chk("cycle_outputs", {17'd0, outv}, {17'd0, e});
      end
   end

   initial begin
      int n;
      ticks(2);
      n_rst = 1;
      chk("reset_outputs", {17'd0, outv}, 0);
      // single ACK through completion and gap
      ack_req = 1; ticks(1); ack_req = 0;
      chk("ack_issue", tx_packet, 2);
      ticks(1); chk("ack_wait_pkt", tx_packet, 0); tx_done = 1;
      ticks(1); tx_done = 0; chk("ack_sent", {ack_sent, nack_sent, data_sent}, 3'b100);
      ticks(4); chk("ack_gap_busy", busy, 1);
      ticks(1); chk("ack_idle", busy, 0);
      // simultaneous ACK and NACK collapse into one NACK
      ack_req = 1; nack_req = 1; ticks(1); ack_req = 0; nack_req = 0;
      chk("nack_issue", tx_packet, 3);
      ticks(1); tx_done = 1;
      ticks(1); tx_done = 0; chk("nack_sent", {ack_sent, nack_sent, data_sent}, 3'b010);
      ticks(5); chk("hs_idle", busy, 0);
      ticks(2); chk("pend_empty", {busy, tx_packet}, 0);
      // data waits for buffer occupancy
      data_req = 1; data_size = 64; occ = 40; ticks(3);
      chk("data_starved", {busy, tx_packet}, 0);
      occ = 64; ticks(1); chk("data_issue", {tx_packet, tx_size}, {2'b01, 7'd64});
      ticks(1); tx_done = 1;
      ticks(1); tx_done = 0; chk("data_sent", {ack_sent, nack_sent, data_sent}, 3'b001);
      data_req = 0; ticks(5); chk("data_idle", busy, 0);
      // handshake beats data in the same IDLE cycle
      data_req = 1; data_size = 10; occ = 64; ack_req = 1; ticks(1); ack_req = 0;
      chk("ack_first", tx_packet, 2);
      ticks(1); tx_done = 1;
      ticks(1); tx_done = 0; chk("ack_first_sent", {ack_sent, data_sent}, 2'b10);
      ticks(5); chk("between_idle", busy, 0);
      ticks(1); chk("data_second", {tx_packet, tx_size}, {2'b01, 7'd10});
      ticks(1); tx_done = 1;
      ticks(1); tx_done = 0; chk("data_second_sent", {ack_sent, data_sent}, 2'b01);
      data_req = 0; ticks(5);
      // watchdog abort
      data_req = 1; data_size = 5; occ = 5; ticks(1);
      chk("to_issue", tx_packet, 1);
      n = 0;
      while (!tx_timeout && n < 200) begin
         ticks(1);
         n++;
      end
      chk("to_distance", n, TO + 1);
      chk("to_data_abort", {data_abort, data_sent}, 2'b10);
      data_req = 0; ticks(GAP + 1); chk("to_idle", busy, 0);
      // reset while waiting for tx_done
      ack_req = 1; ticks(1); ack_req = 0; ticks(1);
      n_rst = 0; ticks(1); n_rst = 1;
      chk("rst_mid", {17'd0, outv}, 0);
      tx_done = 1; ticks(1); tx_done = 0;
      chk("rst_no_sent", {ack_sent, busy}, 0);
      ticks(3);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if (data_req && (data_sent || data_abort)) data_req = 0;
         else if (!data_req && $urandom_range(9) == 0) begin
            data_req = 1;
            data_size = ($urandom_range(3) == 0) ? 7'd0 : 7'($urandom_range(127));
         end
         if ($urandom_range(2) == 0) occ = 7'($urandom_range(127));
         ack_req = ($urandom_range(15) == 0);
         nack_req = ($urandom_range(19) == 0);
         tx_done = (i % 400 < 60) ? 1'b0 : ($urandom_range(5) == 0);
         n_rst = !($urandom_range(399) == 0);
         ticks(1);
      end
      ack_req = 0; nack_req = 0; tx_done = 0; n_rst = 1;
      ticks(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
